vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 tb/tb_vga_timing_gen.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing source for the display path. Walks (hpos, vpos) over the full
// H_TOTAL x V_TOTAL raster, one position per clock, and produces sync, visible,
// line/frame strobes and a frame counter. All outputs are registered from the
// same next-position values, so every output in a cycle describes the
// (hpos, vpos) shown in that cycle.
//
// Optional build macro: VGA_TIMING_PIX_CE_EN
//   defined   -> adds input pix_ce; the raster advances only on edges with
//                pix_ce=1, and line_start/frame_start last one clk after the
//                advancing edge.
//   undefined -> no pix_ce port; the raster advances on every clk.
//
// Ports:
//   clk          in   pixel clock
//   rst_n        in   synchronous active-low reset
//   pix_ce       in   pixel clock enable (only with VGA_TIMING_PIX_CE_EN)
//   hsync        out  horizontal sync, active level SYNC_POL
//   vsync        out  vertical sync, active level SYNC_POL
//   hpos         out  current column, 0..H_TOTAL-1
//   vpos         out  current line, 0..V_TOTAL-1
//   visible      out  1 inside the H_DISPLAY x V_DISPLAY region
//   line_start   out  one-clk pulse when hpos becomes 0
//   frame_start  out  one-clk pulse when (hpos, vpos) becomes (0, 0)
//   frame_count  out  frames completed, increments on entry to vertical blank

module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOP     = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef VGA_TIMING_PIX_CE_EN
    input  logic       pix_ce,
`endif
    output logic       hsync,
    output logic       vsync,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       visible,
    output logic       line_start,
    output logic       frame_start,
    output logic [9:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
        end
    endgenerate

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS_END  = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    logic       advance;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;

`ifdef VGA_TIMING_PIX_CE_EN
    assign advance = pix_ce;
`else
    assign advance = 1'b1;
`endif

    // Next raster position; outputs are all derived from these so they stay
    // coherent with the registered hpos/vpos.
    always_comb begin
        h_nxt = hpos;
        v_nxt = vpos;
        if (hpos == H_LAST) begin
            h_nxt = 10'd0;
            v_nxt = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
        end else begin
            h_nxt = hpos + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos        <= H_LAST;
            vpos        <= V_LAST;
            visible     <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 10'd0;
        end else begin
            // Strobes are one clk wide regardless of how long pix_ce stays low.
            line_start  <= advance && (h_nxt == 10'd0);
            frame_start <= advance && (h_nxt == 10'd0) && (v_nxt == 10'd0);
            if (advance) begin
                hpos    <= h_nxt;
                vpos    <= v_nxt;
                visible <= (h_nxt < H_VIS_END) && (v_nxt < V_VIS_END);
                hsync   <= ((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
                vsync   <= ((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
                if ((h_nxt == 10'd0) && (v_nxt == V_VIS_END)) begin
                    frame_count <= frame_count + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    // Small raster so that more than 1024 frames fit in a short run.
    localparam int HD = 4, HF = 1, HS = 2, HB = 1;
    localparam int VD = 3, VB = 1, VS = 1, VT = 1;
    localparam bit SP = 1'b0;
    localparam int HT = HD + HF + HS + HB;      // 8
    localparam int VTOT = VD + VB + VS + VT;    // 6
    localparam int FRAME = HT * VTOT;           // 48
    localparam int VBLANK_T = VD * HT;          // tick index of (0, VD)

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [9:0] hp;
        logic [9:0] vp;
        logic       vis;
        logic       ls;
        logic       fs;
        logic [9:0] fc;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_ce = 1'b1;
    logic       hsync, vsync, visible, line_start, frame_start;
    logic [9:0] hpos, vpos, frame_count;

    int   errors = 0;
    int   checks = 0;
    int   t = -1;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT),
        .SYNC_POL(SP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef VGA_TIMING_PIX_CE_EN
        .pix_ce(pix_ce),
`endif
        .hsync(hsync),
        .vsync(vsync),
        .hpos(hpos),
        .vpos(vpos),
        .visible(visible),
        .line_start(line_start),
        .frame_start(frame_start),
        .frame_count(frame_count)
    );

    // Reference: position is a pure function of ticks since reset release.
    function automatic obs_t model(input int tick, input bit adv);
        obs_t e;
        int   h, v, n;
        if (tick < 0) begin
            e.hp = 10'(HT - 1); e.vp = 10'(VTOT - 1);
            e.vis = 1'b0; e.hs = ~SP; e.vs = ~SP;
            e.ls = 1'b0; e.fs = 1'b0; e.fc = 10'd0;
            return e;
        end
        h = tick % HT;
        v = (tick / HT) % VTOT;
        n = (tick >= VBLANK_T) ? ((tick - VBLANK_T) / FRAME + 1) : 0;
        e.hp  = 10'(h);
        e.vp  = 10'(v);
        e.vis = (h < HD) && (v < VD);
        e.hs  = (h >= HD + HF && h < HD + HF + HS) ? SP : ~SP;
        e.vs  = (v >= VD + VB && v < VD + VB + VS) ? SP : ~SP;
        e.ls  = adv && (h == 0);
        e.fs  = adv && (h == 0) && (v == 0);
        e.fc  = 10'(n % 1024);
        return e;
    endfunction

    function automatic bit rand_ce();
`ifdef VGA_TIMING_PIX_CE_EN
        return ($urandom_range(0, 3) != 0);
`else
        return 1'b1;
`endif
    endfunction

    // Drive inputs for the next edge and queue the state that edge must produce.
    task automatic step(input bit r, input bit ce);
        bit adv;
        @(negedge clk);
        rst_n  = r;
        pix_ce = ce;
        adv = 1'b0;
`ifndef VGA_TIMING_PIX_CE_EN
        ce = 1'b1;
`endif
        if (!r) begin
            t = -1;
        end else if (ce) begin
            t++;
            adv = 1'b1;
        end
        exp_q.push_back(model(t, adv));
    endtask

    // Monitor: pops one expectation per clk once stimulus has queued one.
    initial begin
        obs_t got, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = '{hs: hsync, vs: vsync, hp: hpos, vp: vpos, vis: visible,
                        ls: line_start, fs: frame_start, fc: frame_count};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL raster @%0t got hp=%0d vp=%0d vis=%b hs=%b vs=%b ls=%b fs=%b fc=%0d exp hp=%0d vp=%0d vis=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                             $time, got.hp, got.vp, got.vis, got.hs, got.vs, got.ls, got.fs, got.fc,
                             e.hp, e.vp, e.vis, e.hs, e.vs, e.ls, e.fs, e.fc);
                end
            end
        end
    end

    initial begin
        repeat (3) step(1'b0, rand_ce());
        // Uninterrupted run past 1025 vblank entries to cover the counter wrap.
        while (t < 1026 * FRAME) step(1'b1, rand_ce());
`ifdef VGA_TIMING_PIX_CE_EN
        for (int i = 0; i < 200; i++) step(1'b1, i[0]);
`endif
        // Random mid-frame resets.
        for (int i = 0; i < 3000; i++) step($urandom_range(0, 39) != 0, rand_ce());
        for (int i = 0; i < 2 * FRAME; i++) step(1'b1, rand_ce());
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
